sss_stream_generator: RTL and testbench

//  Parametrised LTE secondary synchronisation signal generator (36.211 s6.11.2).

---
 rtl/sss_pkg.sv | 41 ++++
 rtl/sss_stream_generator_if.sv | 31 +++
 rtl/sss_m_index.sv | 53 +++++
 rtl/sss_stream_generator.sv | 140 ++++++++++++++
 tb/tb_sss_stream_generator.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sss_pkg.sv
// Shared constants, FSM state type and mod-31 helper for the SSS generator.
// The three x-sequences are built at elaboration from their recursions.
package sss_pkg;

   localparam int SEQ_LEN  = 31;
   localparam int NID1_MAX = 167;
   localparam int NID2_MAX = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_GEN
   } state_e;

   // taps[k] set means x(i+k) feeds x(i+5); seed x(0..4) = 0,0,0,0,1
   function automatic logic [30:0] gen_seq(input logic [4:0] taps);
      logic [35:0] x;
      x = 36'h10;
      for (int i = 0; i < SEQ_LEN; i++) begin
         x[i+5] = ^(x[i +: 5] & taps);
      end
      return x[30:0];
   endfunction

   localparam logic [30:0] S_SEQ = gen_seq(5'b00101);
   localparam logic [30:0] C_SEQ = gen_seq(5'b01001);
   localparam logic [30:0] Z_SEQ = gen_seq(5'b10111);

   function automatic logic [4:0] mod31_add(
      input logic [4:0] a,
      input logic [4:0] b
   );
      logic [5:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 6'd31) begin
         s = s - 6'd31;
      end
      return s[4:0];
   endfunction

endpackage

// File: rtl/sss_stream_generator_if.sv
// Request, stream and status signals of the SSS generator.
// The generator takes the slave modport; the config/RE-mapper side takes master.
interface sss_stream_generator_if #(
   parameter int LANES  = 2,
   parameter int NID2_W = 2
);
   logic              start;
   logic              in_ready;
   logic [7:0]        n_id_1;
   logic [NID2_W-1:0] n_id_2;
   logic              subframe5;
   logic              out_valid;
   logic              out_ready;
   logic [LANES-1:0]  out_data;
   logic              out_last;
   logic [61:0]       sss_vec;
   logic              done;
   logic              err;

   modport master (
      output start, n_id_1, n_id_2, subframe5, out_ready,
      input  in_ready, out_valid, out_data, out_last,
      input  sss_vec, done, err
   );

   modport slave (
      input  start, n_id_1, n_id_2, subframe5, out_ready,
      output in_ready, out_valid, out_data, out_last,
      output sss_vec, done, err
   );
endinterface

// File: rtl/sss_m_index.sv
// Combinational N_ID_1 -> {m0, m1}; divisions by 30/31 are compare chains
// since every quotient involved is at most 6.
module sss_m_index
   import sss_pkg::*;
(
   input  logic [7:0] n_id_1_i,
   output logic [4:0] m0_o,
   output logic [4:0] m1_o
);

   function automatic logic [2:0] div_small(
      input logic [7:0] v,
      input int         d
   );
      logic [2:0] q;
      q = 3'd0;
      for (int k = 1; k <= 6; k++) begin
         if (int'(v) >= k * d) begin
            q = 3'(k);
         end
      end
      return q;
   endfunction

   function automatic logic [4:0] tri_num(input logic [2:0] q);
      logic [4:0] t;
      unique case (q)
         3'd0:    t = 5'd0;
         3'd1:    t = 5'd1;
         3'd2:    t = 5'd3;
         3'd3:    t = 5'd6;
         3'd4:    t = 5'd10;
         3'd5:    t = 5'd15;
         default: t = 5'd21;
      endcase
      return t;
   endfunction

   logic [2:0] qp, q, k;
   logic [7:0] t, mp, m0w;

   always_comb begin
      qp  = div_small(n_id_1_i, 30);
      t   = n_id_1_i + {3'b000, tri_num(qp)};
      q   = div_small(t, 30);
      mp  = n_id_1_i + {3'b000, tri_num(q)};
      k   = div_small(mp, 31);
      m0w = mp - 8'(int'(k) * 31);
      m0_o = m0w[4:0];
      m1_o = mod31_add(m0w[4:0], {2'b00, k} + 5'd1);
   end

endmodule

// File: rtl/sss_stream_generator.sv
// LTE SSS generator: computes m0/m1, then streams d(0..61) LANES bits per beat
// over valid/ready while assembling the full 62-bit vector.
module sss_stream_generator #(
   parameter int LANES  = 2,
   parameter int NID2_W = 2
) (
   input logic                   clk,
   input logic                   reset_n,
   sss_stream_generator_if.slave bus
);
   import sss_pkg::*;

   state_e           state_q, state_d;
   logic [7:0]       n1_q;
   logic [1:0]       n2_q;
   logic             sf5_q;
   logic [4:0]       m0_q, m1_q;
   logic [4:0]       m0_c, m1_c;
   logic [4:0]       n_q;
   logic             ph_q;
   logic [61:0]      vec_q, vec_d;
   logic             done_q, err_q;
   logic             req_ok, accept, fire, last_c;
   logic [4:0]       ma, mb, zsh, n2x;
   logic             e_even, e_odd;
   logic             in_ready_c, out_valid_c;
   logic [LANES-1:0] data_c;

   sss_m_index u_midx (
      .n_id_1_i (n1_q),
      .m0_o     (m0_c),
      .m1_o     (m1_c)
   );

   assign req_ok = (bus.n_id_1 <= 8'(NID1_MAX))
                && (bus.n_id_2 <= NID2_W'(NID2_MAX));
   assign accept = bus.start && in_ready_c;
   assign fire   = out_valid_c && bus.out_ready;
   assign last_c = (n_q == 5'd30) && ((LANES == 2) || ph_q);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept && req_ok) state_d = ST_CALC;
         ST_CALC: state_d = ST_GEN;
         ST_GEN:  if (fire && last_c) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Subframe 5 swaps the roles of m0 and m1, including the z shift
   always_comb begin
      ma     = sf5_q ? m1_q : m0_q;
      mb     = sf5_q ? m0_q : m1_q;
      zsh    = {2'b00, ma[2:0]};
      n2x    = {3'b000, n2_q};
      e_even = S_SEQ[mod31_add(n_q, ma)]
             ^ C_SEQ[mod31_add(n_q, n2x)];
      e_odd  = S_SEQ[mod31_add(n_q, mb)]
             ^ C_SEQ[mod31_add(mod31_add(n_q, n2x), 5'd3)]
             ^ Z_SEQ[mod31_add(n_q, zsh)];
   end

   always_comb begin
      in_ready_c  = (state_q == ST_IDLE);
      out_valid_c = (state_q == ST_GEN);
      data_c      = '0;
      if (out_valid_c) begin
         if (LANES == 2) begin
            data_c = LANES'({e_odd, e_even});
         end else begin
            data_c = LANES'(ph_q ? e_odd : e_even);
         end
      end
   end

   always_comb begin
      vec_d = vec_q;
      if (accept && req_ok) begin
         vec_d = '0;
      end else if (fire) begin
         if ((LANES == 2) || !ph_q) vec_d[{n_q, 1'b0}] = e_even;
         if ((LANES == 2) || ph_q)  vec_d[{n_q, 1'b1}] = e_odd;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         n1_q   <= '0;
         n2_q   <= '0;
         sf5_q  <= 1'b0;
         m0_q   <= '0;
         m1_q   <= '0;
         n_q    <= '0;
         ph_q   <= 1'b0;
         vec_q  <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         vec_q  <= vec_d;
         done_q <= fire && last_c;
         err_q  <= accept && !req_ok;
         if (accept) begin
            n1_q  <= bus.n_id_1;
            n2_q  <= bus.n_id_2[1:0];
            sf5_q <= bus.subframe5;
         end
         if (state_q == ST_CALC) begin
            m0_q <= m0_c;
            m1_q <= m1_c;
            n_q  <= '0;
            ph_q <= 1'b0;
         end else if (fire) begin
            if ((LANES == 1) && !ph_q) begin
               ph_q <= 1'b1;
            end else begin
               ph_q <= 1'b0;
               n_q  <= n_q + 5'd1;
            end
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_data  = data_c;
   assign bus.out_last  = out_valid_c && last_c;
   assign bus.sss_vec   = vec_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_sss_stream_generator.sv
// Directed bench for sss_stream_generator (LANES=2 and LANES=1 instances)
// against a behavioural SSS model built from the 36.211 definitions.
module tb_sss_stream_generator;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   errs = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   sss_stream_generator_if #(.LANES(2), .NID2_W(2)) b2 ();
   sss_stream_generator_if #(.LANES(1), .NID2_W(2)) b1 ();

   sss_stream_generator #(.LANES(2), .NID2_W(2)) dut2 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b2.slave)
   );

   sss_stream_generator #(.LANES(1), .NID2_W(2)) dut1 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b1.slave)
   );

   logic [7:0] mi_n1;
   logic [4:0] mi_m0, mi_m1;

   sss_m_index u_mi (
      .n_id_1_i (mi_n1),
      .m0_o     (mi_m0),
      .m1_o     (mi_m1)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] model_m(input int n1);
      int qp, q, mp, m0, m1;
      qp = n1 / 30;
      q  = (n1 + qp * (qp + 1) / 2) / 30;
      mp = n1 + q * (q + 1) / 2;
      m0 = mp % 31;
      m1 = (m0 + mp / 31 + 1) % 31;
      return {5'(m0), 5'(m1)};
   endfunction

   function automatic logic [61:0] model_sss(input int n1, input int n2,
                                             input bit sf5);
      bit xs[0:30];
      bit xc[0:30];
      bit xz[0:30];
      logic [9:0] mm;
      int m0, m1, ma, mb;
      logic [61:0] d;
      for (int i = 0; i < 5; i++) begin
         xs[i] = (i == 4);
         xc[i] = (i == 4);
         xz[i] = (i == 4);
      end
      for (int i = 0; i < 26; i++) begin
         xs[i+5] = xs[i+2] ^ xs[i];
         xc[i+5] = xc[i+3] ^ xc[i];
         xz[i+5] = xz[i+4] ^ xz[i+2] ^ xz[i+1] ^ xz[i];
      end
      mm = model_m(n1);
      m0 = int'(mm[9:5]);
      m1 = int'(mm[4:0]);
      ma = sf5 ? m1 : m0;
      mb = sf5 ? m0 : m1;
      d = '0;
      for (int n = 0; n < 31; n++) begin
         d[2*n]   = xs[(n + ma) % 31] ^ xc[(n + n2) % 31];
         d[2*n+1] = xs[(n + mb) % 31] ^ xc[(n + n2 + 3) % 31]
                  ^ xz[(n + (ma % 8)) % 31];
      end
      return d;
   endfunction

   // Starts both instances together (ready held high) and collects both streams
   task automatic run_both(input int n1, input int n2, input bit sf5);
      logic [61:0] exp, got2, got1;
      int k2, k1;
      bit d2, d1, last2_ok, last1_ok;
      exp = model_sss(n1, n2, sf5);
      got2 = '0;
      got1 = '0;
      k2 = 0;
      k1 = 0;
      d2 = 1'b0;
      d1 = 1'b0;
      last2_ok = 1'b1;
      last1_ok = 1'b1;
      b2.n_id_1 = 8'(n1);
      b2.n_id_2 = 2'(n2);
      b2.subframe5 = sf5;
      b1.n_id_1 = 8'(n1);
      b1.n_id_2 = 2'(n2);
      b1.subframe5 = sf5;
      b2.out_ready = 1'b1;
      b1.out_ready = 1'b1;
      b2.start = 1'b1;
      b1.start = 1'b1;
      @(negedge clk);
      b2.start = 1'b0;
      b1.start = 1'b0;
      for (int cyc = 0; cyc < 100 && !(d2 && d1); cyc++) begin
         if (b2.out_valid && b2.out_ready) begin
            if (k2 < 31) got2[2*k2 +: 2] = b2.out_data;
            if (b2.out_last !== (k2 == 30)) last2_ok = 1'b0;
            k2++;
         end
         if (b1.out_valid && b1.out_ready) begin
            if (k1 < 62) got1[k1] = b1.out_data[0];
            if (b1.out_last !== (k1 == 61)) last1_ok = 1'b0;
            k1++;
         end
         if (b2.done) begin
            d2 = 1'b1;
            chk("sweep_vec_l2", 64'(b2.sss_vec), 64'(exp));
         end
         if (b1.done) begin
            d1 = 1'b1;
            chk("sweep_vec_l1", 64'(b1.sss_vec), 64'(exp));
         end
         @(negedge clk);
      end
      chk("sweep_done", 64'({d2, d1}), 64'(2'b11));
      chk("sweep_stream_l2", 64'(got2), 64'(exp));
      chk("sweep_stream_l1", 64'(got1), 64'(exp));
      chk("sweep_beats_l2", 64'(k2), 64'(31));
      chk("sweep_beats_l1", 64'(k1), 64'(62));
      chk("sweep_last", 64'({last2_ok, last1_ok}), 64'(2'b11));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [61:0] exp;
      logic [61:0] got;
      logic [1:0]  prev_data;
      logic        prev_last;
      bit          stalled, stable_ok, dn, r;
      int          k;

      b2.start = 1'b0;
      b2.n_id_1 = '0;
      b2.n_id_2 = '0;
      b2.subframe5 = 1'b0;
      b2.out_ready = 1'b0;
      b1.start = 1'b0;
      b1.n_id_1 = '0;
      b1.n_id_2 = '0;
      b1.subframe5 = 1'b0;
      b1.out_ready = 1'b0;
      mi_n1 = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(b2.in_ready), 64'(1));
      chk("rst_out_valid", 64'(b2.out_valid), 64'(0));
      chk("rst_out_data", 64'(b2.out_data), 64'(0));
      chk("rst_out_last", 64'(b2.out_last), 64'(0));
      chk("rst_sss_vec", 64'(b2.sss_vec), 64'(0));
      chk("rst_done_err", 64'({b2.done, b2.err}), 64'(0));
      chk("rst_l1_status", 64'({b1.in_ready, b1.out_valid, b1.done}),
          64'(3'b100));
      reset_n = 1'b1;
      @(negedge clk);

      // m-index hand values, then whole valid range against the model
      mi_n1 = 8'd0;
      #1 chk("midx_0", 64'({mi_m0, mi_m1}), 64'({5'd0, 5'd1}));
      mi_n1 = 8'd30;
      #1 chk("midx_30", 64'({mi_m0, mi_m1}), 64'({5'd0, 5'd2}));
      mi_n1 = 8'd31;
      #1 chk("midx_31", 64'({mi_m0, mi_m1}), 64'({5'd1, 5'd3}));
      mi_n1 = 8'd167;
      #1 chk("midx_167", 64'({mi_m0, mi_m1}), 64'({5'd2, 5'd9}));
      for (int n1 = 0; n1 < 168; n1++) begin
         mi_n1 = 8'(n1);
         #1 chk("midx_sweep", 64'({mi_m0, mi_m1}), 64'(model_m(n1)));
      end
      @(negedge clk);

      // Latency and beat count, N1=0 N2=0 subframe 0, ready held high
      b2.n_id_1 = 8'd0;
      b2.n_id_2 = 2'd0;
      b2.subframe5 = 1'b0;
      b2.out_ready = 1'b1;
      b2.start = 1'b1;
      @(negedge clk);
      b2.start = 1'b0;
      chk("lat_calc_valid", 64'(b2.out_valid), 64'(0));
      chk("lat_calc_in_ready", 64'(b2.in_ready), 64'(0));
      @(negedge clk);
      chk("lat_first_valid", 64'(b2.out_valid), 64'(1));
      chk("lat_beat0_data", 64'(b2.out_data), 64'(2'b00));
      chk("lat_beat0_last", 64'(b2.out_last), 64'(0));
      @(negedge clk);
      chk("lat_beat1_data", 64'(b2.out_data), 64'(2'b10));
      repeat (29) @(negedge clk);
      chk("lat_beat30_last", 64'(b2.out_last), 64'(1));
      chk("lat_beat30_done", 64'(b2.done), 64'(0));
      @(negedge clk);
      chk("lat_done_pulse", 64'(b2.done), 64'(1));
      chk("lat_done_in_ready", 64'(b2.in_ready), 64'(1));
      chk("lat_done_valid", 64'(b2.out_valid), 64'(0));
      chk("lat_vec", 64'(b2.sss_vec), 64'(model_sss(0, 0, 1'b0)));
      @(negedge clk);
      chk("lat_done_cleared", 64'(b2.done), 64'(0));

      // Rejected requests
      b2.n_id_1 = 8'd200;
      b2.n_id_2 = 2'd0;
      b2.start = 1'b1;
      @(negedge clk);
      b2.start = 1'b0;
      chk("err_n1_pulse", 64'(b2.err), 64'(1));
      chk("err_n1_in_ready", 64'(b2.in_ready), 64'(1));
      chk("err_n1_valid", 64'(b2.out_valid), 64'(0));
      @(negedge clk);
      chk("err_n1_clear", 64'({b2.err, b2.out_valid}), 64'(0));
      b2.n_id_1 = 8'd10;
      b2.n_id_2 = 2'd3;
      b2.start = 1'b1;
      @(negedge clk);
      b2.start = 1'b0;
      chk("err_n2_pulse", 64'(b2.err), 64'(1));
      chk("err_n2_in_ready", 64'(b2.in_ready), 64'(1));
      @(negedge clk);
      chk("err_n2_clear", 64'({b2.err, b2.out_valid, b2.in_ready}),
          64'(3'b001));

      // Random backpressure
      exp = model_sss(100, 1, 1'b1);
      got = '0;
      k = 0;
      dn = 1'b0;
      stalled = 1'b0;
      stable_ok = 1'b1;
      prev_data = '0;
      prev_last = 1'b0;
      b2.n_id_1 = 8'd100;
      b2.n_id_2 = 2'd1;
      b2.subframe5 = 1'b1;
      b2.out_ready = 1'b0;
      b2.start = 1'b1;
      @(negedge clk);
      b2.start = 1'b0;
      for (int cyc = 0; cyc < 300 && !dn; cyc++) begin
         if (b2.out_valid) begin
            if (stalled) begin
               if (b2.out_data !== prev_data || b2.out_last !== prev_last)
                  stable_ok = 1'b0;
            end
            r = 1'($urandom_range(0, 1));
            b2.out_ready = r;
            if (r) begin
               if (k < 31) got[2*k +: 2] = b2.out_data;
               k++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               prev_data = b2.out_data;
               prev_last = b2.out_last;
            end
         end else begin
            b2.out_ready = 1'b0;
         end
         if (b2.done) dn = 1'b1;
         @(negedge clk);
      end
      b2.out_ready = 1'b1;
      chk("bp_done", 64'(dn), 64'(1));
      chk("bp_beats", 64'(k), 64'(31));
      chk("bp_stream", 64'(got), 64'(exp));
      chk("bp_stable", 64'(stable_ok), 64'(1));
      chk("bp_vec", 64'(b2.sss_vec), 64'(exp));
      @(negedge clk);

      // Reset during beat 10
      exp = model_sss(57, 2, 1'b0);
      b2.n_id_1 = 8'd57;
      b2.n_id_2 = 2'd2;
      b2.subframe5 = 1'b0;
      b2.out_ready = 1'b1;
      b2.start = 1'b1;
      @(negedge clk);
      b2.start = 1'b0;
      repeat (11) @(negedge clk);
      chk("rstmid_beat10_valid", 64'(b2.out_valid), 64'(1));
      chk("rstmid_beat10_data", 64'(b2.out_data), 64'(exp[21:20]));
      reset_n = 1'b0;
      @(negedge clk);
      chk("rstmid_in_ready", 64'(b2.in_ready), 64'(1));
      chk("rstmid_outputs",
          64'({b2.out_valid, b2.out_data, b2.out_last, b2.done, b2.err}),
          64'(0));
      chk("rstmid_vec", 64'(b2.sss_vec), 64'(0));
      reset_n = 1'b1;
      @(negedge clk);
      run_both(57, 2, 1'b0);

      // Full sweep on both lane widths
      for (int n1 = 0; n1 < 168; n1++) begin
         for (int n2 = 0; n2 < 3; n2++) begin
            for (int sf = 0; sf < 2; sf++) begin
               run_both(n1, n2, sf[0]);
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
